// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: parametrised, pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Latency: a beat captured at edge N is presented on out_valid after edge N+STAGES-1; throughput 1 beat/cycle.
// Backpressure: out_valid && !out_ready freezes every stage; in_ready = !out_valid || out_ready (combinational).
//
// Ports:
//   clk, rst_n                    clock; synchronous active-low reset
//   in_valid/in_ready             operand handshake; a, b, cin, sub (and sat) captured together
//   out_valid/out_ready           result handshake; s, cout, ovf, zero held stable while stalled
// Optional feature macro: PCLA_SAT_EN adds the sat input and output-stage saturation.
//
// Structure: stage 1 is the input register, stage STAGES the output register. The WIDTH/BLOCK
// lookahead groups are spread over the STAGES-1 combinational segments between them. Each
// intermediate register carries the operands, the sum bits finished so far and the carry into
// the first unfinished group.
module cla_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int BLOCK  = 4,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PCLA_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG   = WIDTH / BLOCK;  // number of lookahead groups
  localparam int NSEG = STAGES - 1;     // combinational segments between registers
  localparam int MSB  = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bp;   // B after subtract inversion
    logic [WIDTH-1:0] s;    // sum bits produced by earlier segments
    logic             c;    // carry into the first group not yet summed
`ifdef PCLA_SAT_EN
    logic             sub;
    logic             sat;
`endif
  } beat_t;

  // First group handled by segment k; segment k covers [grp_lo(k), grp_lo(k+1)).
  function automatic int grp_lo(input int k);
    return (k * NG) / NSEG;
  endfunction

  // Lookahead carries for one BLOCK-bit group: every carry is a flat sum of
  // products of the propagate/generate bits, no ripple between bit positions.
  function automatic logic [BLOCK:0] la_carry(input logic [BLOCK-1:0] p,
                                              input logic [BLOCK-1:0] g,
                                              input logic             ci);
    logic [BLOCK:0] c;
    logic           pr;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i <= BLOCK; i++) begin
      pr = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (pr & g[j]);
        pr   = pr & p[j];
      end
      c[i] = c[i] | (pr & ci);
    end
    return c;
  endfunction

  logic              adv;
  logic [NSEG-1:0]   vld_q;
  beat_t             stg_q [NSEG];   // stg_q[0] is the input register
  beat_t             stg_d [NSEG];   // result of segment k, feeds stg_q[k+1] or the output stage

  logic [NG-1:0]     grp_p;
  logic [NG-1:0]     grp_g;
  logic [NG:0]       grp_c;
  logic [BLOCK-1:0]  bit_p;
  logic [BLOCK-1:0]  bit_g;
  logic [BLOCK:0]    bit_c;
  logic              la_acc;
  logic              la_pr;

  logic [WIDTH-1:0]  res_s;
  logic              res_ovf;

  // The whole pipe moves as one; an empty stage still shifts down as a bubble.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Carry-lookahead segments. Group P/G first, then each group carry-in as a
  // flat lookahead term from the segment's registered carry, then the sums.
  always_comb begin
    grp_p  = '0;
    grp_g  = '0;
    grp_c  = '0;
    bit_p  = '0;
    bit_g  = '0;
    bit_c  = '0;
    la_acc = 1'b0;
    la_pr  = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      stg_d[k] = stg_q[k];

      for (int g = grp_lo(k); g < grp_lo(k + 1); g++) begin
        bit_p    = stg_q[k].a[g*BLOCK +: BLOCK] ^ stg_q[k].bp[g*BLOCK +: BLOCK];
        bit_g    = stg_q[k].a[g*BLOCK +: BLOCK] & stg_q[k].bp[g*BLOCK +: BLOCK];
        bit_c    = la_carry(bit_p, bit_g, 1'b0);
        grp_p[g] = &bit_p;
        grp_g[g] = bit_c[BLOCK];
      end

      for (int g = grp_lo(k); g <= grp_lo(k + 1); g++) begin
        la_acc = 1'b0;
        la_pr  = 1'b1;
        for (int j = g - 1; j >= grp_lo(k); j--) begin
          la_acc = la_acc | (la_pr & grp_g[j]);
          la_pr  = la_pr & grp_p[j];
        end
        grp_c[g] = la_acc | (la_pr & stg_q[k].c);
      end

      for (int g = grp_lo(k); g < grp_lo(k + 1); g++) begin
        bit_p = stg_q[k].a[g*BLOCK +: BLOCK] ^ stg_q[k].bp[g*BLOCK +: BLOCK];
        bit_g = stg_q[k].a[g*BLOCK +: BLOCK] & stg_q[k].bp[g*BLOCK +: BLOCK];
        bit_c = la_carry(bit_p, bit_g, grp_c[g]);
        stg_d[k].s[g*BLOCK +: BLOCK] = bit_p ^ bit_c[BLOCK-1:0];
      end

      stg_d[k].c = grp_c[grp_lo(k + 1)];
    end
  end

  // Output-stage result. Overflow is judged on the raw (unsaturated) sum
  // against the inverted B seen by the adder.
  always_comb begin
    res_s   = stg_d[NSEG-1].s;
    res_ovf = (stg_d[NSEG-1].a[MSB] == stg_d[NSEG-1].bp[MSB]) &&
              (stg_d[NSEG-1].s[MSB] != stg_d[NSEG-1].a[MSB]);
`ifdef PCLA_SAT_EN
    if (stg_d[NSEG-1].sat) begin
      if (!stg_d[NSEG-1].sub && stg_d[NSEG-1].c) begin
        res_s = '1;
      end else if (stg_d[NSEG-1].sub && !stg_d[NSEG-1].c) begin
        res_s = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q     <= '0;
      for (int k = 0; k < NSEG; k++) begin
        stg_q[k] <= '0;
      end
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        stg_q[0].a  <= a;
        stg_q[0].bp <= sub ? ~b : b;
        stg_q[0].s  <= '0;
        stg_q[0].c  <= sub ? ~cin : cin;   // borrow-in becomes inverted carry-in
`ifdef PCLA_SAT_EN
        stg_q[0].sub <= sub;
        stg_q[0].sat <= sat;
`endif
      end
      for (int k = 1; k < NSEG; k++) begin
        vld_q[k] <= vld_q[k-1];
        stg_q[k] <= stg_d[k-1];
      end
      out_valid <= vld_q[NSEG-1];
      // Bubbles leave the last result in place rather than loading garbage.
      if (vld_q[NSEG-1]) begin
        s    <= res_s;
        cout <= stg_d[NSEG-1].c;
        ovf  <= res_ovf;
        zero <= (res_s == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
module tb_cla_adder_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef PCLA_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  // Reference: {ovf, cout, s}. Subtraction via true borrow and signed range check.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W:0] wide;
    int         ia, ib, sr;
    logic       c, o;
    ia = $signed(ma);
    ib = $signed(mb);
    if (!msub) begin
      wide = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
      c    = wide[W];
      sr   = ia + ib + int'(mcin);
    end else begin
      wide = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mcin};
      c    = ~wide[W];
      sr   = ia - ib - int'(mcin);
    end
    o = (sr > 32767) || (sr < -32768);
    return {o, c, wide[W-1:0]};
  endfunction

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one beat into an empty pipe and waits (bounded) for its result;
  // lat counts falling edges after the accept edge until out_valid.
  task automatic send_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tcin, input logic tsub, input logic tsat,
                         output int lat);
    @(negedge clk);
    a = ta; b = tbv; cin = tcin; sub = tsub; sat = tsat;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      tests++; if (s !== 16'h0000)    begin fails++; $display("FAIL reset_s: got %h want 0000", s); end
      tests++; if (cout !== 1'b0)     begin fails++; $display("FAIL reset_cout: got %b want 0", cout); end
      tests++; if (ovf !== 1'b0)      begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      tests++; if (zero !== 1'b0)     begin fails++; $display("FAIL reset_zero: got %b want 0", zero); end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
    end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_arith;
    logic [W-1:0] va [8] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h1234, 16'h8000, 16'h0F0F, 16'h0000, 16'h8000};
    logic [W-1:0] vb [8] = '{16'hFFFF, 16'h0001, 16'h0007, 16'h1234, 16'h0001, 16'h00F1, 16'h0000, 16'h8000};
    logic         vc [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] es [8] = '{16'hFFFF, 16'h8000, 16'hFFFE, 16'h0000, 16'h7FFF, 16'h1001, 16'hFFFF, 16'h0000};
    logic         ec [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         eo [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         ez [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    idle(4);
    for (int i = 0; i < 8; i++) begin
      send_op(va[i], vb[i], vc[i], vs[i], 1'b0, lat);
      tests++; if (lat !== 2)       begin fails++; $display("FAIL arith%0d_latency: got %0d want 2", i, lat); end
      tests++; if (s !== es[i])     begin fails++; $display("FAIL arith%0d_s: got %h want %h", i, s, es[i]); end
      tests++; if (cout !== ec[i])  begin fails++; $display("FAIL arith%0d_cout: got %b want %b", i, cout, ec[i]); end
      tests++; if (ovf !== eo[i])   begin fails++; $display("FAIL arith%0d_ovf: got %b want %b", i, ovf, eo[i]); end
      tests++; if (zero !== ez[i])  begin fails++; $display("FAIL arith%0d_zero: got %b want %b", i, zero, ez[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ta [8];
    logic [W-1:0] tbv [8];
    logic         tc [8];
    logic         ts [8];
    logic [W+1:0] ex [8];
    for (int i = 0; i < 8; i++) begin
      ta[i]  = W'(i * 16'h2345 + 16'h00F0);
      tbv[i] = W'(16'h9000 - i * 16'h0B0D);
      tc[i]  = i[1];
      ts[i]  = i[0];
      ex[i]  = model(ta[i], tbv[i], tc[i], ts[i]);
    end
    idle(4);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 3 && c < 11) begin
        tests++;
        if (out_valid !== 1'b1 || s !== ex[c-3][W-1:0] || cout !== ex[c-3][W] || ovf !== ex[c-3][W+1]) begin
          fails++;
          $display("FAIL b2b%0d: got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b",
                   c - 3, out_valid, s, cout, ovf, ex[c-3][W-1:0], ex[c-3][W], ex[c-3][W+1]);
        end
      end else begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle%0d: got v=%b want 0", c, out_valid); end
      end
      if (c < 8) begin
        a = ta[c]; b = tbv[c]; cin = tc[c]; sub = ts[c]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      #1;
      if (c < 8) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready%0d: got %b want 1", c, in_ready); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0]   lfsr = 8'hA5;
    int           sent = 0;
    int           rcv = 0;
    logic         stall = 1'b0;
    logic [W-1:0] held = '0;
    idle(4);
    for (int cyc = 0; cyc < 400 && rcv < 20; cyc++) begin
      @(negedge clk);
      if (stall) begin
        tests++;
        if (out_valid !== 1'b1 || s !== held) begin
          fails++; $display("FAIL bp_stable: got v=%b s=%h want v=1 s=%h", out_valid, s, held);
        end
      end
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      out_ready = lfsr[0];
      in_valid  = (sent < 20);
      a = W'(sent + 1); b = W'(sent + 1); cin = 1'b0; sub = 1'b0; sat = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        tests++;
        if (s !== W'(2 * (rcv + 1))) begin
          fails++; $display("FAIL bp_order%0d: got %h want %h", rcv, s, W'(2 * (rcv + 1)));
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      stall = out_valid && !out_ready;
      held  = s;
      if (stall) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0 during stall", in_ready); end
      end
    end
    tests++; if (rcv !== 20) begin fails++; $display("FAIL bp_count: got %0d results want 20 (sent %0d)", rcv, sent); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_extra: got v=%b s=%h want no further result", out_valid, s); end
    end
  endtask

  task automatic test_mid_reset;
    int lat;
    idle(4);
    // Two beats accepted, a third offered on the reset edge itself.
    a = 16'd100; b = 16'd200; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    a = 16'd300; b = 16'd400;
    @(negedge clk);
    a = 16'd500; b = 16'd600; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_leak%0d: got v=%b s=%h want 0", i, out_valid, s); end
      @(negedge clk);
    end
    send_op(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0, lat);
    tests++; if (lat !== 2)      begin fails++; $display("FAIL mid_reset_latency: got %0d want 2", lat); end
    tests++; if (s !== 16'h0406) begin fails++; $display("FAIL mid_reset_s: got %h want 0406", s); end
  endtask

`ifdef PCLA_SAT_EN
  task automatic test_sat;
    int lat;
    idle(4);
    send_op(16'hFFF0, 16'h0020, 1'b0, 1'b0, 1'b1, lat);
    tests++; if (s !== 16'hFFFF) begin fails++; $display("FAIL sat_add_s: got %h want FFFF", s); end
    tests++; if (cout !== 1'b1)  begin fails++; $display("FAIL sat_add_cout: got %b want 1", cout); end
    send_op(16'h0003, 16'h0009, 1'b0, 1'b1, 1'b1, lat);
    tests++; if (s !== 16'h0000) begin fails++; $display("FAIL sat_sub_s: got %h want 0000", s); end
    tests++; if (zero !== 1'b1)  begin fails++; $display("FAIL sat_sub_zero: got %b want 1", zero); end
    tests++; if (cout !== 1'b0)  begin fails++; $display("FAIL sat_sub_cout: got %b want 0", cout); end
    send_op(16'hFFF0, 16'h0020, 1'b0, 1'b0, 1'b0, lat);
    tests++; if (s !== 16'h0010) begin fails++; $display("FAIL wrap_add_s: got %h want 0010", s); end
    send_op(16'h0003, 16'h0009, 1'b0, 1'b1, 1'b0, lat);
    tests++; if (s !== 16'hFFFA) begin fails++; $display("FAIL wrap_sub_s: got %h want FFFA", s); end
    tests++; if (zero !== 1'b0)  begin fails++; $display("FAIL wrap_sub_zero: got %b want 0", zero); end
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
`ifdef PCLA_SAT_EN
    test_sat();
`endif
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
